// File: rtl/zilla_data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: sequencer state encodings.
`timescale 1ns/1ps
package zilla_data_mem_resp_pkg;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/zilla_data_mem_resp_bank.sv
// Byte-lane word RAM: one lane-enabled write port, one synchronous read port.
// Read-during-write to the same word returns the previously stored data.
`timescale 1ns/1ps
module zilla_data_mem_resp_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk_i,
    input  logic                       wrEn_i,
    input  logic [$clog2(DEPTH)-1:0]   wrIdx_i,
    input  logic [DATA_WIDTH-1:0]      wrData_i,
    input  logic [DATA_WIDTH/8-1:0]    wrLane_i,
    input  logic                       rdEn_i,
    input  logic [$clog2(DEPTH)-1:0]   rdIdx_i,
    output logic [DATA_WIDTH-1:0]      rdData_o
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (wrLane_i[i]) begin
                    mem_q[wrIdx_i][8*i +: 8] <= wrData_i[8*i +: 8];
                end
            end
        end
        if (rdEn_i) begin
            rdData_q <= mem_q[rdIdx_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/zilla_data_mem_resp.sv
// Memory-side responder for the core data port: windowed byte-strobed RAM with
// write-first forwarding, out-of-window error pulse and post-reset zero-fill.
`timescale 1ns/1ps
module zilla_data_mem_resp
    import zilla_data_mem_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
    parameter bit                    INIT_ZERO  = 1'b1
) (
    input  logic                     mem_clk,
    input  logic                     mem_rst,
    input  logic                     data_mem_write_en,
    input  logic [DATA_WIDTH-1:0]    data_mem_write_addr,
    input  logic [DATA_WIDTH-1:0]    data_mem_write_data,
    input  logic [DATA_WIDTH/8-1:0]  data_mem_strobe,
    input  logic                     data_mem_read_en,
    input  logic [DATA_WIDTH-1:0]    data_mem_read_addr,
    output logic [DATA_WIDTH-1:0]    data_mem_read_data,
    output logic                     mem_addr_err,
    output logic                     mem_init_busy
);

    localparam int                    LANES     = DATA_WIDTH / 8;
    localparam int                    LSB       = $clog2(LANES);
    localparam int                    IDXW      = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] WIN_BYTES = DATA_WIDTH'(DEPTH * LANES);
    localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [IDXW-1:0]       fillIdx_q, fillIdx_d;
    logic                  rdPend_q, rdHit_q, addrErr_q;
    logic [LANES-1:0]      fwdLane_q, fwdLane_d;
    logic [DATA_WIDTH-1:0] fwdData_q, hold_q;

    logic [DATA_WIDTH-1:0] wrOff, rdOff, bankRd, merged, readData;
    logic [IDXW-1:0]       wrIdx, rdIdx, bankWrIdx;
    logic                  ready, wrInWin, rdInWin, wrFire, rdFire, rdHit, errNow;

    assign wrOff   = data_mem_write_addr - BASE_ADDR;
    assign rdOff   = data_mem_read_addr - BASE_ADDR;
    assign wrInWin = (data_mem_write_addr >= BASE_ADDR) && (wrOff < WIN_BYTES);
    assign rdInWin = (data_mem_read_addr >= BASE_ADDR) && (rdOff < WIN_BYTES);
    assign wrIdx   = wrOff[LSB +: IDXW];
    assign rdIdx   = rdOff[LSB +: IDXW];

    assign ready   = (state_q == ST_READY);
    assign wrFire  = ready && data_mem_write_en && wrInWin;
    assign rdFire  = ready && data_mem_read_en;
    assign rdHit   = rdFire && rdInWin;
    assign errNow  = ready && ((data_mem_read_en && !rdInWin) || (data_mem_write_en && !wrInWin));

    // The fill sequencer borrows the bank write port until the first READY cycle.
    assign bankWrIdx = ready ? wrIdx : fillIdx_q;

    zilla_data_mem_resp_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) uBank (
        .clk_i    (mem_clk),
        .wrEn_i   (!ready || wrFire),
        .wrIdx_i  (bankWrIdx),
        .wrData_i (ready ? data_mem_write_data : '0),
        .wrLane_i (ready ? data_mem_strobe : '1),
        .rdEn_i   (rdHit),
        .rdIdx_i  (rdIdx),
        .rdData_o (bankRd)
    );

    always_comb begin
        state_d   = state_q;
        fillIdx_d = fillIdx_q;
        if (state_q == ST_INIT) begin
            fillIdx_d = fillIdx_q + IDXW'(1);
            if (fillIdx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
    end

    // Bank read returns old data on a same-word collision, so remember the lanes to patch.
    assign fwdLane_d = (rdHit && wrFire && (rdIdx == wrIdx)) ? data_mem_strobe : '0;

    always_comb begin
        merged = bankRd;
        for (int i = 0; i < LANES; i++) begin
            if (fwdLane_q[i]) begin
                merged[8*i +: 8] = fwdData_q[8*i +: 8];
            end
        end
        readData = hold_q;
        if (rdPend_q) begin
            readData = rdHit_q ? merged : '0;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q   <= INIT_ZERO ? ST_INIT : ST_READY;
            fillIdx_q <= '0;
            rdPend_q  <= 1'b0;
            rdHit_q   <= 1'b0;
            addrErr_q <= 1'b0;
            fwdLane_q <= '0;
            fwdData_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            fillIdx_q <= fillIdx_d;
            rdPend_q  <= rdFire;
            rdHit_q   <= rdHit;
            addrErr_q <= errNow;
            fwdLane_q <= fwdLane_d;
            fwdData_q <= data_mem_write_data;
            hold_q    <= readData;
        end
    end

    assign data_mem_read_data = readData;
    assign mem_addr_err       = addrErr_q;
    assign mem_init_busy      = !ready;

endmodule

// File: tb/tb_zilla_data_mem_resp.sv
// Scoreboard bench for zilla_data_mem_resp: directed and random requests against
// a word-array reference model, with an independent per-cycle output monitor.
`timescale 1ns/1ps
module tb_zilla_data_mem_resp;

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrEn = 1'b0;
    logic [31:0] wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [3:0]  strobe = '0;
    logic        rdEn = 1'b0;
    logic [31:0] rdAddr = '0;
    logic [31:0] rdData;
    logic        addrErr;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    exp_t        expQ[$];
    logic [31:0] modelMem [1024];
    logic [31:0] lastData = '0;
    bit          rstS, busyS, reqS;
    int          fillCount;

    zilla_data_mem_resp #(
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .BASE_ADDR  (32'h1000),
        .INIT_ZERO  (1'b1)
    ) dut (
        .mem_clk             (clk),
        .mem_rst             (rst),
        .data_mem_write_en   (wrEn),
        .data_mem_write_addr (wrAddr),
        .data_mem_write_data (wrData),
        .data_mem_strobe     (strobe),
        .data_mem_read_en    (rdEn),
        .data_mem_read_addr  (rdAddr),
        .data_mem_read_data  (rdData),
        .mem_addr_err        (addrErr),
        .mem_init_busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic bit inWin(logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h2000);
    endfunction

    function automatic int idxOf(logic [31:0] a);
        return int'((a - 32'h1000) >> 2);
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1024; i++) modelMem[i] = '0;
    endtask

    // One request cycle; the expected response is derived from the word-array model.
    task automatic applyStimulus(bit we, logic [31:0] wa, logic [31:0] wd, logic [3:0] st,
                                 bit re, logic [31:0] ra);
        exp_t e;
        @(negedge clk);
        wrEn = we; wrAddr = wa; wrData = wd; strobe = st;
        rdEn = re; rdAddr = ra;
        if (!busy && !rst && (we || re)) begin
            e.err = (re && !inWin(ra)) || (we && !inWin(wa));
            if (we && inWin(wa)) begin
                for (int i = 0; i < 4; i++) begin
                    if (st[i]) modelMem[idxOf(wa)][8*i +: 8] = wd[8*i +: 8];
                end
            end
            e.isRead = re;
            e.data   = (re && inWin(ra)) ? modelMem[idxOf(ra)] : 32'h0;
            expQ.push_back(e);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    task automatic waitFill(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0FFC;
        if (r == 1) return 32'h2000;
        if (r == 2) return $urandom;
        return 32'h1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    endfunction

    // Monitor: every cycle is an output; requests pop the scoreboard, others must hold.
    always @(posedge clk) begin
        exp_t e;
        rstS  = rst;
        busyS = busy;
        reqS  = rdEn || wrEn;
        #1;
        if (rstS) begin
            expQ.delete();
            lastData = '0;
            checkOutput("resetData", rdData, 32'h0);
            checkOutput("resetErr", {31'b0, addrErr}, 32'h0);
        end else if (!busyS && reqS) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardEmpty", 32'h1, 32'h0);
            end else begin
                e = expQ.pop_front();
                if (e.isRead) lastData = e.data;
                checkOutput("respData", rdData, lastData);
                checkOutput("respErr", {31'b0, addrErr}, {31'b0, e.err});
            end
        end else begin
            checkOutput("holdData", rdData, lastData);
            checkOutput("idleErr", {31'b0, addrErr}, 32'h0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        checkOutput("busyAfterReset", {31'b0, busy}, 32'h1);
        waitFill(fillCount);
        checkOutput("fillCycles", 32'(fillCount), 32'd1024);

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1FFC);
        applyStimulus(1'b1, 32'h1010, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
        applyStimulus(1'b1, 32'h1010, 32'h11223344, 4'b0101, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1013);
        applyStimulus(1'b1, 32'h1020, 32'h12345678, 4'b1111, 1'b0, '0);
        applyStimulus(1'b1, 32'h1020, 32'hDEADBEEF, 4'b0011, 1'b1, 32'h1020);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1020);
        idle(1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h0FFC);
        idle(1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h2000);
        applyStimulus(1'b1, 32'h2000, 32'hCAFEF00D, 4'b1111, 1'b0, '0);
        applyStimulus(1'b1, 32'h1000, 32'h5A5A5A5A, 4'b0000, 1'b1, 32'h1000);
        applyStimulus(1'b1, 32'h2000, 32'h1, 4'b1111, 1'b1, 32'h0FFC);
        idle(2);

        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 32'h1000 + 32'(i * 4), 32'(i) * 32'h01010101, 4'b1111, 1'b0, '0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1000 + 32'(i * 4));
        idle(1);

        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom, 4'($urandom),
                          1'($urandom_range(0, 1)), randAddr());
        idle(2);

        doReset();
        for (int i = 0; i < 500; i++)
            applyStimulus(1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1'b1, (i % 2 == 0) ? 32'h2000 : 32'h1000);
        checkOutput("busyMidFill", {31'b0, busy}, 32'h1);
        doReset();
        waitFill(fillCount);
        checkOutput("refillCycles", 32'(fillCount), 32'd1024);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1000);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1010);
        idle(3);

        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
